system_exec_ctrl: RTL and testbench
===================================

// Module: system_exec_ctrl
// PURPOSE
// Sequencer for decoded SYSTEM instructions (system_kind_t from instr_type) in the execute stage.
// Runs the CSR read-modify-write transaction against the CSR file over a req/ack port.
// Raises traps for ecall, ebreak, invalid encodings and illegal CSR accesses.
// Sits between decode_system and the CSR file; produces the rd writeback and a retire/trap pulse.
// PARAMETERS
// XLEN            32  data width of rs1 value, CSR data and rd writeback
// TIMEOUT_CYCLES  16  cycles without csr_ack before timeout trap (only with SYSEXEC_TIMEOUT_EN)
// PORTS
// clk          in   1      clock; all state updates on rising edge
// rst          in   1      synchronous, active-high reset
// in_valid     in   1      instruction presented
// in_ready     out  1      block can accept; high only in IDLE
// kind         in   system_kind_t  decoded SYSTEM kind
// csr_addr     in   12     CSR address (instr[31:20])
// rs1_idx      in   5      rs1 field; used as uimm for *I forms
// rs1_val      in   XLEN   rs1 register value
// rd_idx       in   5      destination register index
// csr_req      out  1      CSR transaction request; held until csr_ack
// csr_we       out  1      1 = write, 0 = read; valid while csr_req
// csr_addr_o   out  12     CSR address of the transaction
// csr_wdata    out  XLEN   write data; valid while csr_req & csr_we
// csr_rdata    in   XLEN   read data; sampled when csr_ack & ~csr_we
// csr_ack      in   1      transaction complete this cycle
// csr_err      in   1      with csr_ack: nonexistent/privilege-violating CSR
// done         out  1      1-cycle pulse: instruction retired or trapped
// trap         out  1      with done: instruction trapped
// trap_cause   out  4      with trap: 2 illegal instr, 3 breakpoint, 11 ecall-M
// rd_we        out  1      with done: write rd_data to rd_idx
// rd_addr      out  5      latched rd_idx
// rd_data      out  XLEN   old CSR value
// BEHAVIOUR
// - Reset: state IDLE; in_ready=1; all other outputs 0. rst mid-transaction: abandon it, csr_req=0 next cycle, no done.
// - Accept: in_valid & in_ready latches kind, addr, rs1_idx, rs1_val, rd_idx.
// - src = rs1_val for CSRRW/S/C; zero-extended rs1_idx for CSRRWI/SI/CI.
// - do_read = !(CSRRW* & rd_idx==0).
// - do_write = CSRRW* | (rs1_idx != 0).
// - FSM:
//   - IDLE -> TRAP on ecall / ebreak / invalid.
//   - IDLE -> TRAP when do_write & csr_addr[11:10]==2'b11 (read-only CSR); cause 2, no CSR access.
//   - IDLE -> READ if do_read, else -> WRITE.
//   - READ: csr_req=1, csr_we=0. On ack: if csr_err -> TRAP (cause 2); else latch old=csr_rdata, then -> WRITE if do_write, else -> DONE.
//   - WRITE: csr_req=1, csr_we=1, csr_wdata = src (W) | old|src (S) | old&~src (C). On ack: if csr_err -> TRAP (cause 2), else -> DONE.
//   - DONE: done=1, rd_we = do_read & rd_idx!=0, rd_data=old; -> IDLE.
//   - TRAP: done=1, trap=1, rd_we=0; -> IDLE.
// - Kind mapping: ecall -> cause 11; ebreak -> cause 3; invalid -> cause 2.
// - Latency (accept in cycle 0, ack in the request cycle):
//   - read+write: done in cycle 3.
//   - read-only or write-only: done in cycle 2.
//   - trap from IDLE: done in cycle 1.
// - csr_addr_o is stable while csr_req; csr_req never deasserts before csr_ack (except rst).
// - csr_err without csr_ack is ignored; csr_ack outside READ/WRITE is ignored.
// - Write data that depends on old uses the value read in this instruction; no forwarding.
// CONFIGURATION
// SYSEXEC_TIMEOUT_EN defined:
//   - Counter resets on entering READ/WRITE; increments each cycle csr_req & ~csr_ack.
//   - Reaching TIMEOUT_CYCLES -> TRAP, cause 2; csr_req drops that cycle.
// SYSEXEC_TIMEOUT_EN undefined: no counter; READ/WRITE wait indefinitely for csr_ack.
// TESTING
// - Reset: hold rst 2 cycles mid-READ -> csr_req=0, done=0, in_ready=1 the cycle after release.
// - CSRRS rd=5 rs1_idx=3 rs1_val=0x0F, addr 0x300, rdata 0xF0, ack same cycle:
//   - csr_wdata=0xFF; done cycle 3; rd_we=1, rd_addr=5, rd_data=0xF0.
// - CSRRW rd=0 src 0x1234: no read transaction; one write 0x1234; done cycle 2; rd_we=0.
// - CSRRCI rs1_idx=0 rd=7, rdata 0xAA: read only, no write; rd_data=0xAA.
// - CSRRC rs1_val=0x0F, rdata 0xFF, ack delayed 3 cycles on each transaction:
//   - csr_req held, csr_wdata=0xF0; done cycle 9.
// - Trap kinds:
//   - ecall -> trap, cause 11, cycle 1.
//   - ebreak -> trap, cause 3.
//   - invalid -> trap, cause 2.
//   - CSRRW to 0xC00 -> cause 2, no csr_req.
//   - csr_err on read -> cause 2, rd_we=0.
// - SYSEXEC_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> trap cause 2 after 16 cycles in READ.

Source files
------------

// File: rtl/system_exec_ctrl.sv
// system_exec_ctrl: execute-stage sequencer for decoded SYSTEM instructions.
// Runs the CSR read-modify-write transaction over a req/ack port. Traps on
// ecall, ebreak, invalid encodings, writes to read-only CSRs and CSR errors.
// Optional feature: define SYSEXEC_TIMEOUT_EN to trap (cause 2) when the CSR
// file leaves a request unacknowledged for TIMEOUT_CYCLES cycles.

package instr_type;
    typedef enum logic [3:0] {
        SYS_INVALID = 4'd0,
        SYS_ECALL   = 4'd1,
        SYS_EBREAK  = 4'd2,
        SYS_CSRRW   = 4'd3,
        SYS_CSRRS   = 4'd4,
        SYS_CSRRC   = 4'd5,
        SYS_CSRRWI  = 4'd6,
        SYS_CSRRSI  = 4'd7,
        SYS_CSRRCI  = 4'd8
    } system_kind_t;
endpackage

module system_exec_ctrl
    import instr_type::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  system_kind_t    kind,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      rs1_idx,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [4:0]      rd_idx,
    output logic            csr_req,
    output logic            csr_we,
    output logic [11:0]     csr_addr_o,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic            csr_ack,
    input  logic            csr_err,
    output logic            done,
    output logic            trap,
    output logic [3:0]      trap_cause,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_TRAP} state_t;
    typedef enum logic [1:0] {OP_W, OP_S, OP_C} op_t;

    state_t          state, next_state;
    op_t             op_q, acc_op;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] src_q, old_q, acc_src, wdata;
    logic [4:0]      rd_q;
    logic [3:0]      cause_q, acc_cause;
    logic            do_read_q, do_write_q;
    logic            is_csr, is_imm, is_rw;
    logic            acc_do_read, acc_do_write, acc_ro_viol, accept;
    logic            timeout_hit;

    // Decode the presented instruction into operation, operand source and trap cause
    always_comb begin
        is_csr    = 1'b0;
        is_imm    = 1'b0;
        is_rw     = 1'b0;
        acc_op    = OP_W;
        acc_cause = 4'd2;
        case (kind)
            SYS_ECALL:  acc_cause = 4'd11;
            SYS_EBREAK: acc_cause = 4'd3;
            SYS_CSRRW:  begin is_csr = 1'b1; is_rw = 1'b1; acc_op = OP_W; end
            SYS_CSRRS:  begin is_csr = 1'b1; acc_op = OP_S; end
            SYS_CSRRC:  begin is_csr = 1'b1; acc_op = OP_C; end
            SYS_CSRRWI: begin is_csr = 1'b1; is_imm = 1'b1; is_rw = 1'b1; acc_op = OP_W; end
            SYS_CSRRSI: begin is_csr = 1'b1; is_imm = 1'b1; acc_op = OP_S; end
            SYS_CSRRCI: begin is_csr = 1'b1; is_imm = 1'b1; acc_op = OP_C; end
            default:    acc_cause = 4'd2;
        endcase
    end

    assign acc_src      = is_imm ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_val;
    assign acc_do_read  = !(is_rw && (rd_idx == 5'd0));
    assign acc_do_write = is_rw || (rs1_idx != 5'd0);
    assign acc_ro_viol  = acc_do_write && (csr_addr[11:10] == 2'b11);
    assign accept       = in_valid && in_ready;

    // Latch the instruction on accept and capture the old CSR value on a clean read
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_W;
            addr_q     <= '0;
            src_q      <= '0;
            old_q      <= '0;
            rd_q       <= '0;
            cause_q    <= '0;
            do_read_q  <= 1'b0;
            do_write_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= acc_op;
                addr_q     <= csr_addr;
                src_q      <= acc_src;
                old_q      <= '0;
                rd_q       <= rd_idx;
                cause_q    <= acc_cause;
                do_read_q  <= acc_do_read;
                do_write_q <= acc_do_write;
            end
            if (state == S_READ && csr_ack && !csr_err) begin
                old_q <= csr_rdata;
            end
            if (state == S_READ || state == S_WRITE) begin
                cause_q <= 4'd2;
            end
        end
    end

`ifdef SYSEXEC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q;

    // Watchdog: restart on every state change, count unacknowledged request cycles
    always_ff @(posedge clk) begin
        if (rst || (next_state != state)) begin
            timer_q <= '0;
        end else if (csr_req && !csr_ack) begin
            timer_q <= timer_q + TW'(1);
        end
    end

    assign timeout_hit = csr_req && !csr_ack && (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        csr_req    = 1'b0;
        csr_we     = 1'b0;
        done       = 1'b0;
        trap       = 1'b0;
        rd_we      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (!is_csr || acc_ro_viol) next_state = S_TRAP;
                    else if (acc_do_read)       next_state = S_READ;
                    else                        next_state = S_WRITE;
                end
            end
            S_READ: begin
                csr_req = 1'b1;
                if (csr_ack) begin
                    if (csr_err)         next_state = S_TRAP;
                    else if (do_write_q) next_state = S_WRITE;
                    else                 next_state = S_DONE;
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                end
            end
            S_WRITE: begin
                csr_req = 1'b1;
                csr_we  = 1'b1;
                if (csr_ack) begin
                    next_state = csr_err ? S_TRAP : S_DONE;
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                rd_we      = do_read_q && (rd_q != 5'd0);
                next_state = S_IDLE;
            end
            S_TRAP: begin
                done       = 1'b1;
                trap       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Write data combines the operand with the value read by this same instruction
    always_comb begin
        wdata = src_q;
        case (op_q)
            OP_S:    wdata = old_q | src_q;
            OP_C:    wdata = old_q & ~src_q;
            default: wdata = src_q;
        endcase
    end

    assign csr_addr_o = csr_req ? addr_q : 12'd0;
    assign csr_wdata  = (state == S_WRITE) ? wdata : '0;
    assign trap_cause = trap ? cause_q : 4'd0;
    assign rd_addr    = rd_q;
    assign rd_data    = (state == S_DONE) ? old_q : '0;

endmodule

// File: tb/tb_system_exec_ctrl.sv
// tb_system_exec_ctrl: directed testbench for system_exec_ctrl.
// A small CSR-file responder acks requests after a chosen delay; each test
// task compares the observed transaction and retire results to hand-computed
// values. Define SYSEXEC_TIMEOUT_EN to also exercise the watchdog.

module tb_system_exec_ctrl;
    import instr_type::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    system_kind_t kind;
    logic [11:0]  csr_addr;
    logic [4:0]   rs1_idx;
    logic [31:0]  rs1_val;
    logic [4:0]   rd_idx;
    logic         csr_req;
    logic         csr_we;
    logic [11:0]  csr_addr_o;
    logic [31:0]  csr_wdata;
    logic [31:0]  csr_rdata;
    logic         csr_ack;
    logic         csr_err;
    logic         done;
    logic         trap;
    logic [3:0]   trap_cause;
    logic         rd_we;
    logic [4:0]   rd_addr;
    logic [31:0]  rd_data;

    int checks = 0;
    int errors = 0;

    int          obs_reads, obs_writes, obs_req_cycles, obs_done_cycle;
    logic        obs_ready0, obs_addr_bad, obs_trap, obs_rd_we;
    logic [31:0] obs_wdata, obs_rd_data;
    logic [3:0]  obs_cause;
    logic [4:0]  obs_rd_addr;

    system_exec_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .kind(kind), .csr_addr(csr_addr), .rs1_idx(rs1_idx), .rs1_val(rs1_val),
        .rd_idx(rd_idx), .csr_req(csr_req), .csr_we(csr_we),
        .csr_addr_o(csr_addr_o), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_ack(csr_ack), .csr_err(csr_err), .done(done), .trap(trap),
        .trap_cause(trap_cause), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Present one instruction in cycle 0, answer CSR requests after 'delay'
    // waiting cycles, and record what happens until done or max_cyc expires.
    task automatic run_instr(input system_kind_t k, input logic [11:0] a,
                             input logic [4:0] r1, input logic [31:0] v,
                             input logic [4:0] rd, input logic [31:0] rdata,
                             input bit err_rd, input int delay, input int max_cyc);
        int  wait_cnt;
        bit  done_seen;
        obs_reads = 0; obs_writes = 0; obs_req_cycles = 0; obs_done_cycle = -1;
        obs_addr_bad = 1'b0; obs_wdata = '0; obs_trap = 1'b0; obs_cause = '0;
        obs_rd_we = 1'b0; obs_rd_addr = '0; obs_rd_data = '0;
        @(posedge clk); #1;
        in_valid = 1'b1; kind = k; csr_addr = a; rs1_idx = r1; rs1_val = v; rd_idx = rd;
        #2 obs_ready0 = in_ready;
        wait_cnt  = 0;
        done_seen = 1'b0;
        for (int c = 1; c <= max_cyc && !done_seen; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b0; csr_ack = 1'b0; csr_err = 1'b0;
            if (csr_req) begin
                if (wait_cnt == delay) begin
                    csr_ack   = 1'b1;
                    csr_rdata = rdata;
                    csr_err   = err_rd && !csr_we;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end
            #1;
            if (csr_req) begin
                obs_req_cycles++;
                if (csr_addr_o !== a) obs_addr_bad = 1'b1;
            end
            if (csr_req && csr_ack) begin
                if (csr_we) begin obs_writes++; obs_wdata = csr_wdata; end
                else obs_reads++;
            end
            if (done) begin
                done_seen = 1'b1; obs_done_cycle = c; obs_trap = trap; obs_cause = trap_cause;
                obs_rd_we = rd_we; obs_rd_addr = rd_addr; obs_rd_data = rd_data;
            end
        end
        @(posedge clk); #1;
        csr_ack = 1'b0; csr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; kind = SYS_INVALID; csr_addr = '0; rs1_idx = '0;
        rs1_val = '0; rd_idx = '0; csr_rdata = '0; csr_ack = 1'b0; csr_err = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (csr_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_csr_req: got %b expected 0", csr_req); end
        checks++; if ({done, trap, rd_we} !== 3'b000) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 000", {done, trap, rd_we}); end
        checks++; if ({trap_cause, rd_addr} !== 9'd0 || rd_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_data: got cause %h rd_addr %h rd_data %h expected 0", trap_cause, rd_addr, rd_data); end
        @(posedge clk); #1 rst = 1'b0;
        // start a CSRRS and abandon it mid-READ with a 2-cycle reset
        @(posedge clk); #1;
        in_valid = 1'b1; kind = SYS_CSRRS; csr_addr = 12'h300; rs1_idx = 5'd1; rd_idx = 5'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        checks++; if (csr_req !== 1'b1) begin errors++; $display("[TB] FAIL midread_req: got %b expected 1", csr_req); end
        rst = 1'b1;
        @(posedge clk); #2;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midread_no_done: got %b expected 0", done); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #2;
        checks++; if ({csr_req, done, in_ready} !== 3'b001) begin errors++; $display("[TB] FAIL after_reset: got req/done/ready %b expected 001", {csr_req, done, in_ready}); end
    endtask

    task automatic test_csrrs();
        run_instr(SYS_CSRRS, 12'h300, 5'd3, 32'h0F, 5'd5, 32'hF0, 1'b0, 0, 20);
        checks++; if (obs_ready0 !== 1'b1) begin errors++; $display("[TB] FAIL csrrs_ready: got %b expected 1", obs_ready0); end
        checks++; if (obs_reads !== 1 || obs_writes !== 1) begin errors++; $display("[TB] FAIL csrrs_txns: got %0d reads %0d writes expected 1 1", obs_reads, obs_writes); end
        checks++; if (obs_wdata !== 32'hFF) begin errors++; $display("[TB] FAIL csrrs_wdata: got %h expected 000000ff", obs_wdata); end
        checks++; if (obs_done_cycle !== 3) begin errors++; $display("[TB] FAIL csrrs_latency: got %0d expected 3", obs_done_cycle); end
        checks++; if ({obs_trap, obs_rd_we, obs_rd_addr} !== {1'b0, 1'b1, 5'd5}) begin errors++; $display("[TB] FAIL csrrs_rd: got trap %b rd_we %b rd_addr %0d expected 0 1 5", obs_trap, obs_rd_we, obs_rd_addr); end
        checks++; if (obs_rd_data !== 32'hF0) begin errors++; $display("[TB] FAIL csrrs_rd_data: got %h expected 000000f0", obs_rd_data); end
    endtask

    task automatic test_write_only();
        run_instr(SYS_CSRRW, 12'h340, 5'd4, 32'h1234, 5'd0, 32'hDEAD, 1'b0, 0, 20);
        checks++; if (obs_reads !== 0 || obs_writes !== 1) begin errors++; $display("[TB] FAIL csrrw_txns: got %0d reads %0d writes expected 0 1", obs_reads, obs_writes); end
        checks++; if (obs_wdata !== 32'h1234) begin errors++; $display("[TB] FAIL csrrw_wdata: got %h expected 00001234", obs_wdata); end
        checks++; if (obs_done_cycle !== 2 || obs_rd_we !== 1'b0) begin errors++; $display("[TB] FAIL csrrw_done: got cycle %0d rd_we %b expected 2 0", obs_done_cycle, obs_rd_we); end
    endtask

    task automatic test_read_only();
        run_instr(SYS_CSRRCI, 12'h305, 5'd0, 32'hFFFF, 5'd7, 32'hAA, 1'b0, 0, 20);
        checks++; if (obs_reads !== 1 || obs_writes !== 0) begin errors++; $display("[TB] FAIL csrrci_txns: got %0d reads %0d writes expected 1 0", obs_reads, obs_writes); end
        checks++; if (obs_rd_data !== 32'hAA || obs_rd_we !== 1'b1 || obs_rd_addr !== 5'd7) begin errors++; $display("[TB] FAIL csrrci_rd: got data %h we %b addr %0d expected aa 1 7", obs_rd_data, obs_rd_we, obs_rd_addr); end
        checks++; if (obs_done_cycle !== 2) begin errors++; $display("[TB] FAIL csrrci_latency: got %0d expected 2", obs_done_cycle); end
        // reading a read-only CSR is legal when nothing is written
        run_instr(SYS_CSRRS, 12'hC00, 5'd0, 32'h5, 5'd9, 32'h1234_5678, 1'b0, 0, 20);
        checks++; if (obs_trap !== 1'b0 || obs_rd_data !== 32'h1234_5678 || obs_writes !== 0) begin errors++; $display("[TB] FAIL ro_read: got trap %b data %h writes %0d expected 0 12345678 0", obs_trap, obs_rd_data, obs_writes); end
    endtask

    task automatic test_immediate();
        run_instr(SYS_CSRRSI, 12'h304, 5'd5, 32'hFFFF_0000, 5'd1, 32'h100, 1'b0, 0, 20);
        checks++; if (obs_wdata !== 32'h105) begin errors++; $display("[TB] FAIL csrrsi_wdata: got %h expected 00000105", obs_wdata); end
        run_instr(SYS_CSRRCI, 12'h304, 5'd3, 32'hFFFF_FFFF, 5'd1, 32'hFF, 1'b0, 0, 20);
        checks++; if (obs_wdata !== 32'hFC) begin errors++; $display("[TB] FAIL csrrci_wdata: got %h expected 000000fc", obs_wdata); end
    endtask

    task automatic test_delayed_ack();
        run_instr(SYS_CSRRC, 12'h341, 5'd2, 32'h0F, 5'd6, 32'hFF, 1'b0, 3, 30);
        checks++; if (obs_wdata !== 32'hF0) begin errors++; $display("[TB] FAIL csrrc_wdata: got %h expected 000000f0", obs_wdata); end
        checks++; if (obs_done_cycle !== 9) begin errors++; $display("[TB] FAIL csrrc_latency: got %0d expected 9", obs_done_cycle); end
        checks++; if (obs_req_cycles !== 8 || obs_addr_bad !== 1'b0) begin errors++; $display("[TB] FAIL csrrc_req_hold: got %0d req cycles addr_bad %b expected 8 0", obs_req_cycles, obs_addr_bad); end
    endtask

    task automatic test_traps();
        run_instr(SYS_ECALL, 12'h000, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 0, 10);
        checks++; if ({obs_trap, obs_cause} !== {1'b1, 4'd11} || obs_done_cycle !== 1) begin errors++; $display("[TB] FAIL ecall: got trap %b cause %0d cycle %0d expected 1 11 1", obs_trap, obs_cause, obs_done_cycle); end
        run_instr(SYS_EBREAK, 12'h001, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 0, 10);
        checks++; if ({obs_trap, obs_cause} !== {1'b1, 4'd3}) begin errors++; $display("[TB] FAIL ebreak: got trap %b cause %0d expected 1 3", obs_trap, obs_cause); end
        run_instr(SYS_INVALID, 12'h300, 5'd1, 32'h0, 5'd4, 32'h0, 1'b0, 0, 10);
        checks++; if ({obs_trap, obs_cause, obs_rd_we} !== {1'b1, 4'd2, 1'b0}) begin errors++; $display("[TB] FAIL invalid: got trap %b cause %0d rd_we %b expected 1 2 0", obs_trap, obs_cause, obs_rd_we); end
        run_instr(SYS_CSRRW, 12'hC00, 5'd1, 32'h77, 5'd4, 32'h0, 1'b0, 0, 10);
        checks++; if ({obs_trap, obs_cause} !== {1'b1, 4'd2} || obs_req_cycles !== 0 || obs_done_cycle !== 1) begin errors++; $display("[TB] FAIL ro_write: got trap %b cause %0d reqs %0d cycle %0d expected 1 2 0 1", obs_trap, obs_cause, obs_req_cycles, obs_done_cycle); end
        run_instr(SYS_CSRRS, 12'h7FF, 5'd2, 32'h3, 5'd3, 32'h55, 1'b1, 0, 10);
        checks++; if ({obs_trap, obs_cause, obs_rd_we} !== {1'b1, 4'd2, 1'b0} || obs_writes !== 0) begin errors++; $display("[TB] FAIL csr_err: got trap %b cause %0d rd_we %b writes %0d expected 1 2 0 0", obs_trap, obs_cause, obs_rd_we, obs_writes); end
        checks++; if (obs_done_cycle !== 2) begin errors++; $display("[TB] FAIL csr_err_latency: got %0d expected 2", obs_done_cycle); end
    endtask

    task automatic test_back_to_back();
        // old value must come from this instruction's own read, not the previous one
        run_instr(SYS_CSRRS, 12'h300, 5'd1, 32'h1, 5'd8, 32'h10, 1'b0, 0, 20);
        run_instr(SYS_CSRRS, 12'h300, 5'd1, 32'h2, 5'd8, 32'h40, 1'b0, 0, 20);
        checks++; if (obs_wdata !== 32'h42 || obs_rd_data !== 32'h40) begin errors++; $display("[TB] FAIL b2b: got wdata %h rd_data %h expected 42 40", obs_wdata, obs_rd_data); end
    endtask

`ifdef SYSEXEC_TIMEOUT_EN
    task automatic test_timeout();
        run_instr(SYS_CSRRS, 12'h300, 5'd1, 32'h1, 5'd2, 32'h0, 1'b0, 1000, 40);
        checks++; if ({obs_trap, obs_cause} !== {1'b1, 4'd2} || obs_req_cycles !== 16 || obs_done_cycle !== 17) begin errors++; $display("[TB] FAIL timeout: got trap %b cause %0d reqs %0d cycle %0d expected 1 2 16 17", obs_trap, obs_cause, obs_req_cycles, obs_done_cycle); end
    endtask
`endif

    initial begin
        test_reset();
        test_csrrs();
        test_write_only();
        test_read_only();
        test_immediate();
        test_delayed_ack();
        test_traps();
        test_back_to_back();
`ifdef SYSEXEC_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
